// File: rtl/spi_pkg.sv
// spi_pkg: FSM states and CPOL/CPHA decode helpers.
// Shared by spi_slave and spi_master.
package spi_pkg;
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} spi_state_e;
   function automatic logic cpol(input int mode);
      return mode[1];
   endfunction
   function automatic logic cpha(input int mode);
      return mode[0];
   endfunction
endpackage

// File: rtl/spi_sync.sv
// spi_sync: W-bit two-flop synchronizer with a per-bit reset value.
module spi_sync #(
   parameter int           W       = 1,
   parameter logic [W-1:0] RST_VAL = '0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);
   logic [W-1:0] meta_q;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         meta_q <= RST_VAL;
         q_o    <= RST_VAL;
      end else begin
         meta_q <= d_i;
         q_o    <= meta_q;
      end
endmodule

// File: rtl/spi_slave.sv
// spi_slave: clk-domain SPI slave with a tx holding register and oversampled sclk/ss_n/mosi.
// Defining SPI_SLAVE_ERR_EN adds sticky overrun/underrun/abort flags, err_clr, rx_ack and irq.
module spi_slave
   import spi_pkg::*;
#(
   parameter int MODE             = 3,
   parameter int DATA_WIDTH       = 32,
   parameter int MSB_FIRST        = 1,
   parameter int SLAVE_ACTIVE_LOW = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DATA_WIDTH-1:0] tx_data,
   input  logic                  tx_valid,
   output logic                  tx_ready,
   output logic [DATA_WIDTH-1:0] rx_data,
   output logic                  rx_valid,
   output logic                  busy,
`ifdef SPI_SLAVE_ERR_EN
   input  logic                  rx_ack,
   input  logic                  err_clr,
   output logic                  overrun,
   output logic                  underrun,
   output logic                  abort,
   output logic                  irq,
`endif
   input  logic                  sclk,
   input  logic                  mosi,
   input  logic                  ss_n,
   output logic                  miso,
   output logic                  miso_oe
);
   localparam int   CW  = $clog2(DATA_WIDTH + 1);
   localparam logic POL = cpol(MODE);
   localparam logic PHA = cpha(MODE);
   localparam logic SAL = SLAVE_ACTIVE_LOW != 0;
   localparam logic MSB = MSB_FIRST != 0;
   logic sclk_s, ss_s, mosi_s, sclk_q, ss_q;
   logic ss_on, ss_start, lead, trail, smp, shf, hs, last, start, quit, fire;
   logic [DATA_WIDTH-1:0] tx_sr_q, rx_sr_q, hold_q, rx_data_q, tx_sr_d, rx_sr_d;
   logic [CW-1:0] cnt_q;
   logic tx_ready_q, rx_valid_q, miso_oe_q;
   spi_state_e state_q;
   // ss_n resets to its active level so a frame already under way at reset release is skipped
   spi_sync #(.W(3), .RST_VAL({POL, ~SAL, 1'b0})) u_sync (
      .clk(clk),
      .rst_n(rst_n),
      .d_i({sclk, ss_n, mosi}),
      .q_o({sclk_s, ss_s, mosi_s})
   );
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) {sclk_q, ss_q} <= {POL, ~SAL};
      else        {sclk_q, ss_q} <= {sclk_s, ss_s};
   assign ss_on    = ss_s ^ SAL;
   assign ss_start = ss_on & ~(ss_q ^ SAL);
   assign lead     = (sclk_s ^ POL) & ~(sclk_q ^ POL);
   assign trail    = ~(sclk_s ^ POL) & (sclk_q ^ POL);
   assign smp      = PHA ? trail : lead;
   assign shf      = PHA ? lead : trail;
   assign hs       = tx_valid & tx_ready_q;
   assign last     = cnt_q == CW'(DATA_WIDTH - 1);
   assign start    = state_q == IDLE && ss_start;
   assign quit     = state_q != IDLE && !ss_on;
   assign fire     = state_q == SHIFT && ss_on && smp && last;
   assign tx_sr_d  = MSB ? {tx_sr_q[DATA_WIDTH-2:0], 1'b0} : {1'b0, tx_sr_q[DATA_WIDTH-1:1]};
   assign rx_sr_d  = MSB ? {rx_sr_q[DATA_WIDTH-2:0], mosi_s} : {mosi_s, rx_sr_q[DATA_WIDTH-1:1]};
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         tx_sr_q    <= '0;
         rx_sr_q    <= '0;
         hold_q     <= '0;
         rx_data_q  <= '0;
         tx_ready_q <= 1'b1;
         rx_valid_q <= 1'b0;
         miso_oe_q  <= 1'b0;
      end else begin
         rx_valid_q <= 1'b0;
         if (hs) begin
            hold_q     <= tx_data;
            tx_ready_q <= 1'b0;
         end
         if (start) begin
            state_q    <= SHIFT;
            cnt_q      <= '0;
            tx_sr_q    <= hs ? tx_data : (tx_ready_q ? '0 : hold_q);
            tx_ready_q <= 1'b1;
            miso_oe_q  <= 1'b1;
         end
         if (quit) begin
            state_q   <= IDLE;
            miso_oe_q <= 1'b0;
         end else if (state_q == SHIFT) begin
            if (smp) begin
               rx_sr_q <= rx_sr_d;
               cnt_q   <= cnt_q + CW'(1);
            end
            if (fire) begin
               state_q    <= DONE;
               rx_data_q  <= rx_sr_d;
               rx_valid_q <= 1'b1;
            end
            // with CPHA=1 the first bit is already on miso, so the first leading edge holds it
            if (shf && (!PHA || cnt_q != '0)) tx_sr_q <= tx_sr_d;
         end
      end
   assign tx_ready = tx_ready_q;
   assign rx_data  = rx_data_q;
   assign rx_valid = rx_valid_q;
   assign busy     = state_q != IDLE;
   assign miso     = MSB ? tx_sr_q[DATA_WIDTH-1] : tx_sr_q[0];
   assign miso_oe  = miso_oe_q;
`ifdef SPI_SLAVE_ERR_EN
   logic ovr_q, und_q, abt_q, pend_q;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) {ovr_q, und_q, abt_q, pend_q} <= '0;
      else begin
         pend_q <= fire | (pend_q & ~rx_ack);
         ovr_q  <= (ovr_q & ~err_clr) | (fire & pend_q & ~rx_ack);
         und_q  <= (und_q & ~err_clr) | (start & ~hs & tx_ready_q);
         abt_q  <= (abt_q & ~err_clr) | (quit & (state_q == SHIFT));
      end
   assign overrun  = ovr_q;
   assign underrun = und_q;
   assign abort    = abt_q;
   assign irq      = ovr_q | und_q | abt_q;
`endif
endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: five spi_slave configurations driven by a bit-banged master;
// received words are checked by a scoreboard monitor, miso streams inline.
module tb_spi_slave;
   localparam logic [4:0][1:0] MODES  = {2'd0, 2'd3, 2'd2, 2'd1, 2'd0};
   localparam logic [4:0][5:0] WIDTHS = {6'd8, 6'd32, 6'd32, 6'd32, 6'd8};
   localparam logic [4:0]      MSBF   = 5'b01111;
   localparam int H = 80;
   typedef struct packed {
      logic [2:0]  idx;
      logic [31:0] data;
   } sb_t;
   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic [4:0] sclk, mosi, ss_n, tx_valid, tx_ready, rx_valid, busy, miso, miso_oe;
   logic [4:0][31:0] txd, rxw;
   sb_t sb[$];
   sb_t mon_e;
   int vectors = 0, miscompares = 0;
   always #5 clk = ~clk;
   for (genvar g = 0; g < 5; g++) begin : g_dut
      localparam int W = int'(WIDTHS[g]);
      logic [W-1:0] rxd;
      spi_slave #(
         .MODE(int'(MODES[g])),
         .DATA_WIDTH(W),
         .MSB_FIRST(int'(MSBF[g])),
         .SLAVE_ACTIVE_LOW(1)
      ) u_dut (
         .clk(clk),
         .rst_n(rst_n),
         .tx_data(txd[g][W-1:0]),
         .tx_valid(tx_valid[g]),
         .tx_ready(tx_ready[g]),
         .rx_data(rxd),
         .rx_valid(rx_valid[g]),
         .busy(busy[g]),
         .sclk(sclk[g]),
         .mosi(mosi[g]),
         .ss_n(ss_n[g]),
         .miso(miso[g]),
         .miso_oe(miso_oe[g])
      );
      assign rxw[g] = 32'(rxd);
   end
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask
   always @(negedge clk)
      for (int k = 0; k < 5; k++)
         if (rx_valid[k] === 1'b1) begin
            if (sb.size() == 0) chk($sformatf("unexpected_rx_valid dut%0d", k), 32'(rx_valid[k]), 32'd0);
            else begin
               mon_e = sb.pop_front();
               chk($sformatf("rx_idx dut%0d", k), 32'(k), 32'(mon_e.idx));
               chk($sformatf("rx_data dut%0d", k), rxw[k], mon_e.data);
            end
         end
   task automatic reset_vals(input int i);
      chk($sformatf("reset rx_data dut%0d", i), rxw[i], 32'd0);
      chk($sformatf("reset busy,rx_valid,tx_ready,miso,miso_oe dut%0d", i),
          {27'd0, busy[i], rx_valid[i], tx_ready[i], miso[i], miso_oe[i]}, 32'b00100);
   endtask
   task automatic load(input int i, input logic [31:0] w);
      @(negedge clk);
      txd[i] = w;
      tx_valid[i] = 1'b1;
      @(negedge clk);
      tx_valid[i] = 1'b0;
      chk($sformatf("tx_ready_after_load dut%0d", i), 32'(tx_ready[i]), 32'd0);
   endtask
   // bits < width aborts early; rst_at >= 0 pulses rst_n before that bit
   task automatic frame(input int i, input logic [31:0] mo, input logic [31:0] exp_miso,
                        input int bits, input int rst_at);
      int n = int'(WIDTHS[i]);
      logic pol = MODES[i][1];
      logic pha = MODES[i][0];
      logic msb = MSBF[i];
      logic [31:0] got = '0;
      logic bit_o;
      if (bits == n && rst_at < 0) sb.push_back('{idx: 3'(i), data: mo});
      ss_n[i] = 1'b0;
      #H;
      chk($sformatf("in_frame busy,miso_oe,tx_ready dut%0d", i), {29'd0, busy[i], miso_oe[i], tx_ready[i]}, 32'b111);
      for (int b = 0; b < bits; b++) begin
         if (b == rst_at) begin
            rst_n = 1'b0;
            #20;
            reset_vals(i);
            rst_n = 1'b1;
         end
         bit_o = msb ? mo[n-1-b] : mo[b];
         if (!pha) mosi[i] = bit_o;
         #H;
         if (!pha) got = msb ? {got[30:0], miso[i]} : (got | (32'(miso[i]) << b));
         sclk[i] = ~pol;
         if (pha) mosi[i] = bit_o;
         #H;
         if (pha) got = msb ? {got[30:0], miso[i]} : (got | (32'(miso[i]) << b));
         sclk[i] = pol;
      end
      #H;
      if (rst_at >= 0) chk($sformatf("ignored_after_reset busy dut%0d", i), 32'(busy[i]), 32'd0);
      ss_n[i] = 1'b1;
      mosi[i] = 1'b0;
      #(2 * H);
      chk($sformatf("after_frame busy,miso_oe dut%0d", i), {30'd0, busy[i], miso_oe[i]}, 32'd0);
      if (bits == n && rst_at < 0) chk($sformatf("miso_stream dut%0d", i), got, exp_miso);
   endtask
   initial begin
      for (int k = 0; k < 5; k++) sclk[k] = MODES[k][1];
      ss_n = '1;
      mosi = '0;
      tx_valid = '0;
      txd = '0;
      #2 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      for (int k = 0; k < 5; k++) reset_vals(k);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      load(0, 32'hA5);
      frame(0, 32'h3C, 32'hA5, 8, -1);
      for (int k = 1; k < 4; k++) begin
         load(k, 32'h12345678);
         frame(k, 32'hDEADBEEF, 32'h12345678, 32, -1);
      end
      load(4, 32'hB1);
      frame(4, 32'h01, 32'hB1, 8, -1);
      frame(0, 32'hFF, 32'h00, 8, -1);
      load(0, 32'h5A);
      frame(0, 32'h77, 32'h0, 5, -1);
      load(0, 32'h81);
      frame(0, 32'hC3, 32'h81, 8, -1);
      load(3, 32'hCAFEF00D);
      frame(3, 32'hDEADBEEF, 32'h0, 32, 10);
      load(3, 32'hCAFEF00D);
      frame(3, 32'h0F1E2D3C, 32'hCAFEF00D, 32, -1);
      repeat (10) @(negedge clk);
      chk("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 SHALL have parameter MODE, default 3, SPI mode 0-3 (CPOL = MODE[1], CPHA = MODE[0]).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, frame length in bits (2..32).
REQ-003 SHALL have parameter MSB_FIRST, default 1, 1 = MSB shifted first, 0 = LSB first.
REQ-004 SHALL have parameter SLAVE_ACTIVE_LOW, default 1, ss_n active level (1 = low).
REQ-005 SHALL have port clk, input, 1, system clock, and SHALL run on this one clock only.
REQ-006 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-007 SHALL have port tx_data, input, DATA_WIDTH, word for the next frame.
REQ-008 SHALL have port tx_valid, input, 1, tx_data valid.
REQ-009 SHALL have port tx_ready, output, 1, holding register empty.
REQ-010 SHALL have port rx_data, output, DATA_WIDTH, last complete received word.
REQ-011 SHALL have port rx_valid, output, 1, one-cycle pulse marking a new rx_data.
REQ-012 SHALL have port busy, output, 1, frame in progress.
REQ-013 SHALL have ports sclk, mosi and ss_n, each input, 1, SPI bus from the master, all asynchronous to clk.
REQ-014 SHALL have ports miso, output, 1, and miso_oe, output, 1; miso_oe is high only while ss_n is active.

Function
REQ-015 SHALL pass sclk, ss_n and mosi through 2-flop synchronizers and detect edges against a third registered copy.
REQ-016 SHALL have states IDLE, SHIFT and DONE: IDLE -> SHIFT on the synchronized ss_n active edge; SHIFT -> DONE once DATA_WIDTH sampling edges have been seen; DONE -> IDLE when ss_n goes inactive.
REQ-017 SHALL, on entering SHIFT, load the holding register into the TX shift register, clear the bit counter and set tx_ready=1.
REQ-018 SHALL, if the holding register is empty at frame start, shift out all zeros (underrun).
REQ-019 SHALL, for CPHA=0, present the first bit on miso in the cycle after the ss_n edge is detected, sample on leading edges and shift on trailing edges.
REQ-020 SHALL, for CPHA=1, shift on leading edges and sample on trailing edges.
REQ-021 SHALL ignore sclk edges while in IDLE or DONE.
REQ-022 SHALL update rx_data and pulse rx_valid for exactly 1 cycle, in the clk cycle after the final sampling edge is detected.
REQ-023 SHALL accept a tx handshake (tx_valid && tx_ready) in any state and clear tx_ready the next cycle; a same-cycle handshake and frame start SHALL load the new word into the shift register directly.
REQ-024 SHALL, if ss_n goes inactive in SHIFT (abort), discard the partial frame, produce no rx_valid, return to IDLE and leave the holding register unchanged.
REQ-025 SHALL hold busy=1 in SHIFT and DONE.
REQ-026 SHALL operate correctly only for sclk frequency <= clk/4.

Reset
REQ-027 SHALL reset state to IDLE, counters to 0, rx_data to 0, rx_valid=0, busy=0, tx_ready=1, miso=0 and miso_oe=0 asynchronously on rst_n low.
REQ-028 SHALL, after rst_n deasserts mid-frame, ignore bus activity until ss_n has been seen inactive.

Configuration
REQ-029 SHALL, when macro SPI_SLAVE_ERR_EN is defined, add outputs overrun, underrun, abort (sticky, cleared by input err_clr) and irq = OR of the three.
REQ-030 SHALL set overrun when rx_valid fires while the previous word is unacknowledged via input rx_ack.
REQ-031 SHALL, without SPI_SLAVE_ERR_EN, have none of these ports, with rx_valid, rx_data and tx behaviour unchanged.

Structure
REQ-032 SHALL take the state enum and the CPOL/CPHA decode functions from shared package spi_pkg, which spi_master also uses.
REQ-033 SHALL instantiate sub-module spi_sync (parameterized-width 2-flop synchronizer) once for sclk, ss_n and mosi.

Verification
REQ-034 Mode 0, MSB first, DATA_WIDTH=8, tx 0xA5 loaded, master sends 0x3C -> miso bits 10100101, rx_data=0x3C, single rx_valid pulse.
REQ-035 Each of modes 1, 2 and 3, 32-bit, master sends 0xDEADBEEF, slave tx 0x12345678 -> exact bidirectional match.
REQ-036 MSB_FIRST=0, 8-bit, master 0x01 -> rx_data=0x01, miso sends the tx word LSB first.
REQ-037 No tx_valid before a frame -> miso all zeros; with SPI_SLAVE_ERR_EN, underrun=1 and irq=1.
REQ-038 ss_n deasserted after 5 of 8 bits -> no rx_valid, state IDLE; next full frame receives correctly.
REQ-039 rst_n pulsed mid-frame -> all outputs at reset values; activity ignored until ss_n is inactive, then the next frame is correct.
